data_prbs7_gen: RTL and testbench

- Transmit-side PRBS7 source for the GBCR2 SEU test: drives a 4-lane, 8x-oversampled 32-bit word into the channel under test.
- Its pattern is what `dataPrbs7Check` locks onto and checks on the receive side.
- Injects deliberate single-bit errors on command or periodically.
- Exports a running 16-bit injected-error count that feeds the checker's `injectErrorCount` input, so the measured error count can be matched against the injected count.

---
 rtl/data_prbs7_gen.sv | 143 ++++++++++++++
 tb/tb_data_prbs7_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_prbs7_gen.sv
// data_prbs7_gen
//   Transmit-side PRBS7 source (x^7 + x^6 + 1, period 127) for the GBCR2 SEU
//   test. Each RUN cycle emits four new sequence bits, one per lane, with each
//   bit replicated across the lane's 8 oversampled positions. Single-lane
//   errors can be injected on command, or periodically when built with
//   PRBS7_GEN_PERIODIC_INJECT_EN defined. The running injected-error count is
//   exported so the receive-side checker can match measured vs injected errors.
//
// Parameters
//   SEED             initial PRBS7 state (must be nonzero)
//
// Ports
//   clk              word clock
//   reset            synchronous, active-high reset
//   enable           1 = generate PRBS, 0 = idle
//   injectPulse      one-cycle request to inject one error
//   injectLane[1:0]  lane whose 8 bits are inverted on injection
//   injectPeriod[15:0] periodic injection interval in RUN cycles, 0 = off
//                    (ignored unless PRBS7_GEN_PERIODIC_INJECT_EN is defined)
//   data[31:0]       lane k on data[8k+7:8k]; lane 0 oldest bit, lane 3 newest
//   injectErrorCount[15:0] total injected errors, wraps, cleared by reset only
//   running          high while in RUN
//
// Optional feature macro: PRBS7_GEN_PERIODIC_INJECT_EN
module data_prbs7_gen #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        injectPulse,
  input  logic [1:0]  injectLane,
  input  logic [15:0] injectPeriod,
  output logic [31:0] data,
  output logic [15:0] injectErrorCount,
  output logic        running
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [6:0]  r_st;
  logic [6:0]  w_st_next;
  logic [3:0]  w_bits;
  logic [31:0] w_word;
  logic [31:0] w_lane_mask;
  logic        w_emit;
  logic        w_tick;
  logic        w_inject;
  logic        w_running_next;

  logic [31:0] r_data;
  logic [15:0] r_err_cnt;
  logic        r_running;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (enable)  w_next_state = S_RUN;
      S_RUN:   if (!enable) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: a word is emitted only while RUN and staying in RUN, so the
  // cycle in which enable drops already produces zero output.
  always_comb begin
    w_emit         = (r_state == S_RUN) && enable;
    w_running_next = (w_next_state == S_RUN);
  end

  // st = {b[n-1] .. b[n-7]}; b[n] = b[n-6] ^ b[n-7] = st[1] ^ st[0].
  always_comb begin
    w_bits[0] = r_st[1] ^ r_st[0];
    w_bits[1] = r_st[2] ^ r_st[1];
    w_bits[2] = r_st[3] ^ r_st[2];
    w_bits[3] = r_st[4] ^ r_st[3];
    w_word    = {{8{w_bits[3]}}, {8{w_bits[2]}}, {8{w_bits[1]}}, {8{w_bits[0]}}};
    w_lane_mask = 32'h0000_00FF << {injectLane, 3'b000};
  end

  // State always advances with uncorrupted bits; an all-zero state reloads SEED.
  always_comb begin
    w_st_next = r_st;
    if (r_st == '0)  w_st_next = SEED;
    else if (w_emit) w_st_next = {w_bits[3], w_bits[2], w_bits[1], w_bits[0], r_st[6:4]};
  end

`ifdef PRBS7_GEN_PERIODIC_INJECT_EN
  logic [15:0] r_period_cnt;

  assign w_tick = w_emit && (injectPeriod != '0) &&
                  (r_period_cnt == (injectPeriod - 16'd1));

  always_ff @(posedge clk) begin
    if (reset)       r_period_cnt <= '0;
    else if (!w_emit) r_period_cnt <= '0;
    else if (w_tick) r_period_cnt <= '0;
    else             r_period_cnt <= r_period_cnt + 16'd1;
  end
`else
  logic w_unused_period;

  assign w_tick          = 1'b0;
  assign w_unused_period = ^injectPeriod;
`endif

  // Manual and periodic requests in the same cycle merge into one injection.
  assign w_inject = w_emit && (injectPulse || w_tick);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st      <= SEED;
      r_data    <= '0;
      r_err_cnt <= '0;
      r_running <= 1'b0;
    end else begin
      r_st      <= w_st_next;
      r_running <= w_running_next;
      if (!w_emit)       r_data <= '0;
      else if (w_inject) r_data <= w_word ^ w_lane_mask;
      else               r_data <= w_word;
      if (w_inject) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign data             = r_data;
  assign injectErrorCount = r_err_cnt;
  assign running          = r_running;

endmodule

// File: tb/tb_data_prbs7_gen.sv
// Testbench for data_prbs7_gen: hand-computed vector table for the first
// words after reset, then sequences checked against a bit-serial PRBS7 model.
module tb_data_prbs7_gen;

  localparam logic [6:0] TB_SEED = 7'h7F;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        injectPulse;
  logic [1:0]  injectLane;
  logic [15:0] injectPeriod;
  logic [31:0] data;
  logic [15:0] injectErrorCount;
  logic        running;

  int unsigned n_checks;
  int unsigned n_errors;

  data_prbs7_gen #(.SEED(TB_SEED)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .injectPulse      (injectPulse),
    .injectLane       (injectLane),
    .injectPeriod     (injectPeriod),
    .data             (data),
    .injectErrorCount (injectErrorCount),
    .running          (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        pulse;
    logic [1:0]  lane;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
    logic        exp_run;
  } vec_t;

  vec_t vecs[13];

  // Bit-serial reference: history of the last 7 bits, newest at the back.
  bit hist[$];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 7; i++) hist.push_back(TB_SEED[i]);
  endtask

  task automatic model_word(output logic [31:0] w);
    bit nb;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      nb = hist[hist.size()-6] ^ hist[hist.size()-7];
      hist.push_back(nb);
      void'(hist.pop_front());
      w[8*k +: 8] = {8{nb}};
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [1:0] lane);
    logic [31:0] m;
    m = 32'h0000_00FF;
    return m << (8 * int'(lane));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] exp_d;
    logic [15:0] exp_c;
    logic        inj;

    n_checks = 0;
    n_errors = 0;

    //            en    pulse lane   data           cnt     run
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 16'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 16'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 32'h00FF_FF00, 16'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 16'd1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_FFFF, 16'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 16'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0000, 16'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0000, 16'd1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd0, 32'h00FF_0000, 16'd1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'hFF00_00FF, 16'd2, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FF00, 16'd3, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h00FF_0000, 16'd3, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h0000_0000, 16'd4, 1'b1};

    reset        = 1'b1;
    enable       = 1'b0;
    injectPulse  = 1'b0;
    injectLane   = 2'd0;
    injectPeriod = 16'd0;
    step();
    step();
    check("reset data", data, 32'h0);
    check("reset count", {16'h0, injectErrorCount}, 32'h0);
    check("reset running", {31'h0, running}, 32'h0);
    reset = 1'b0;

    // Hand-computed vectors from SEED 7'h7F
    for (int i = 0; i < 13; i++) begin
      enable      = vecs[i].en;
      injectPulse = vecs[i].pulse;
      injectLane  = vecs[i].lane;
      step();
      check($sformatf("vec%0d data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d count", i), {16'h0, injectErrorCount}, {16'h0, vecs[i].exp_cnt});
      check($sformatf("vec%0d running", i), {31'h0, running}, {31'h0, vecs[i].exp_run});
    end
    injectPulse = 1'b0;
    enable      = 1'b0;

    // 1000 model words with 5 manual injections on lane 2
    do_reset();
    model_reset();
    exp_c      = 16'd0;
    enable     = 1'b1;
    injectLane = 2'd2;
    step();
    check("first edge data", data, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      injectPulse = ((i % 200) == 50);
      model_word(w);
      exp_d = injectPulse ? (w ^ 32'h00FF_0000) : w;
      if (injectPulse) exp_c = exp_c + 16'd1;
      step();
      check($sformatf("run word %0d", i), data, exp_d);
      check($sformatf("run count %0d", i), {16'h0, injectErrorCount}, {16'h0, exp_c});
    end
    injectPulse = 1'b0;
    check("five injections", {16'h0, injectErrorCount}, 32'd5);

    // Idle requests are dropped; sequence resumes after re-enable
    enable      = 1'b0;
    injectPulse = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle data %0d", i), data, 32'h0);
      check($sformatf("idle running %0d", i), {31'h0, running}, 32'h0);
      check($sformatf("idle count %0d", i), {16'h0, injectErrorCount}, 32'd5);
    end
    injectPulse = 1'b0;
    enable      = 1'b1;
    step();
    check("resume first edge data", data, 32'h0);
    check("resume running", {31'h0, running}, 32'h1);
    for (int i = 0; i < 20; i++) begin
      model_word(w);
      step();
      check($sformatf("resume word %0d", i), data, w);
    end

`ifdef PRBS7_GEN_PERIODIC_INJECT_EN
    // Period 100 over 10000 RUN cycles, manual pulse coinciding with a tick
    do_reset();
    model_reset();
    exp_c        = 16'd0;
    injectPeriod = 16'd100;
    injectLane   = 2'd1;
    enable       = 1'b1;
    step();
    for (int i = 0; i < 10000; i++) begin
      injectPulse = (i == 499);
      inj = (((i + 1) % 100) == 0) || injectPulse;
      model_word(w);
      exp_d = inj ? (w ^ lane_mask(2'd1)) : w;
      if (inj) exp_c = exp_c + 16'd1;
      step();
      check($sformatf("periodic word %0d", i), data, exp_d);
    end
    injectPulse = 1'b0;
    check("periodic count", {16'h0, injectErrorCount}, 32'd100);

    // Period 1 injects every word
    injectPeriod = 16'd1;
    injectLane   = 2'd3;
    for (int i = 0; i < 8; i++) begin
      model_word(w);
      exp_c = exp_c + 16'd1;
      step();
      check($sformatf("period1 word %0d", i), data, w ^ lane_mask(2'd3));
    end
    check("period1 count", {16'h0, injectErrorCount}, {16'h0, exp_c});
    injectPeriod = 16'd0;
`else
    // Without the periodic feature injectPeriod has no effect
    injectPeriod = 16'd1;
    for (int i = 0; i < 50; i++) begin
      model_word(w);
      step();
      check($sformatf("no-periodic word %0d", i), data, w);
    end
    check("no-periodic count", {16'h0, injectErrorCount}, 32'd5);
    injectPeriod = 16'd0;
`endif

    // Reset mid-run with a simultaneous injection request
    enable      = 1'b1;
    injectPulse = 1'b1;
    reset       = 1'b1;
    step();
    check("midrun reset data", data, 32'h0);
    check("midrun reset count", {16'h0, injectErrorCount}, 32'h0);
    check("midrun reset running", {31'h0, running}, 32'h0);
    reset       = 1'b0;
    injectPulse = 1'b0;
    model_reset();
    step();
    check("post reset first edge", data, 32'h0);
    for (int i = 0; i < 10; i++) begin
      model_word(w);
      step();
      check($sformatf("post reset word %0d", i), data, w);
    end

    // Count wrap 16'hFFFF -> 16'h0000
    do_reset();
    enable = 1'b1;
    step();
    injectPulse = 1'b1;
    injectLane  = 2'd0;
    for (int i = 0; i < 65535; i++) step();
    check("count at max", {16'h0, injectErrorCount}, 32'h0000_FFFF);
    step();
    check("count wrap", {16'h0, injectErrorCount}, 32'h0);
    injectPulse = 1'b0;
    enable      = 1'b0;
    step();
    check("after wrap idle data", data, 32'h0);
    check("after wrap count", {16'h0, injectErrorCount}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
